operand_dispatcher_n: RTL and testbench
=======================================

// Module: operand_dispatcher_n
// PURPOSE
//  Parametrised N-lane operand dispatcher: accepts one operand per data pointer, routes the batch
//  to N functional units through a rotation crossbar, and registers each routed operand in an
//  output stage with a per-lane valid/ready handshake.
//  Each output lane carries a source tag (which pointer it came from) and a zero flag, used for
//  datapointer-update prediction. Sits between the pointer/data fetch stage and the FU array.
// PARAMETERS
//  WIDTH   16  operand data width in bits
//  LANES   2   number of data pointers = number of FUs (>=2)
//  MODE    0   0: rotation taken from sel_i at each fire; 1: internal round-robin rotation
//  SRC_W   $clog2(LANES) (min 1)  width of one source tag (localparam)
// PORTS
//  clk          in   1              clock, rising edge
//  preset_n     in   1              reset, asynchronous, active-low
//  flush_i      in   1              synchronous flush of output stage and rotation
//  data_i       in   LANES*WIDTH    operand from pointer p at [p*WIDTH +: WIDTH]
//  valid_i      in   LANES          operand p valid
//  ready_o      out  LANES          operand p consumed this cycle
//  sel_i        in   SRC_W          rotation amount (MODE 0 only; ignored in MODE 1)
//  in_zero_o    out  LANES          comb: data_i lane p == 0
//  operand_o    out  LANES*WIDTH    registered operand for FU k
//  op_valid_o   out  LANES          FU k operand valid
//  op_ready_i   in   LANES          FU k accepts operand
//  op_src_o     out  LANES*SRC_W    pointer index that produced operand_o lane k
//  op_zero_o    out  LANES          registered: operand_o lane k == 0
//  rot_o        out  SRC_W          current rotation register
// BEHAVIOUR
//  Reset (preset_n=0, async): op_valid_o=0, operand_o=0, op_src_o=0, op_zero_o=0, rot=0.
//  stage_free = AND over k of (!op_valid_o[k] | op_ready_i[k]).
//  fire = stage_free & (&valid_i) & !flush_i. Batch is all-or-nothing: no partial dispatch.
//  ready_o = {LANES{fire}} (combinational; depends on all valid_i).
//  Rotation r used for a fire: MODE0 -> sel_i (if sel_i>=LANES, use sel_i mod LANES); MODE1 -> rot reg.
//  On fire, for every k: s=(k+r) mod LANES; operand_o[k]<=data_i[s]; op_src_o[k]<=s;
//   op_zero_o[k]<=(data_i[s]==0); op_valid_o[k]<=1. Latency 1 cycle input->output.
//  No fire: lane k with op_valid_o&op_ready_i clears op_valid_o[k]; data/tag/zero hold.
//  Output lanes drain independently; next fire waits until every held lane is taken or taken
//   in the same cycle (full-throughput back-to-back when all op_ready_i=1).
//  rot register: MODE1 increments on each fire, wrapping LANES-1 -> 0; MODE0 rot<=r on fire.
//  flush_i=1: op_valid_o<=0, rot<=0, ready_o=0; operand/tag/zero hold. Flush beats fire.
//  Reset mid-transfer: all held operands are dropped; no output valid until next fire.
//  in_zero_o is purely combinational on data_i, independent of valid_i.
//  LANES=2, MODE0, sel_i=selpath reproduces the legacy 2-way swap with a registered path tag.
// TESTING
//  T1 reset: preset_n low mid-run with op_valid_o=2'b11 -> outputs/tag/rot all 0 same cycle.
//  T2 MODE0 LANES=2: data={0x0005,0x0000}, valid=11, sel=1, op_ready=11 -> next cycle
//     operand_o[0]=0x0005(src1), operand_o[1]=0x0000(src0,op_zero=1); in_zero_o=2'b01 comb.
//  T3 backpressure: op_ready=2'b01 after fire -> lane1 holds, ready_o=0 for new batch until
//     op_ready[1]=1, then fire in that same cycle; no lost/duplicated operand.
//  T4 MODE1 LANES=4: 5 back-to-back fires -> rot sequence 0,1,2,3,0; lane0 src 0,1,2,3,0.
//  T5 partial valid: valid_i=4'b1011 -> ready_o=0, no output change; set 4'b1111 -> fire.
//  T6 flush with fire conditions true -> no fire, op_valid_o=0, rot=0 next cycle.

Source files
------------

// File: rtl/operand_dispatcher_n.sv
// operand_dispatcher_n
// N-lane operand dispatcher. It takes one operand per data pointer, rotates the batch
// through a crossbar onto N functional-unit lanes, and registers each lane behind its own
// valid/ready handshake. Each output lane also carries the index of the pointer that
// produced it and a zero flag, which are used for datapointer-update prediction.
// A batch moves only as a whole: it fires once every pointer presents an operand and every
// output lane is either empty or being drained in the same cycle.

module operand_dispatcher_n #(
  parameter  int WIDTH = 16,
  parameter  int LANES = 2,
  parameter  int MODE  = 0,
  localparam int SRC_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   preset_n,
  input  logic                   flush_i,
  input  logic [LANES*WIDTH-1:0] data_i,
  input  logic [LANES-1:0]       valid_i,
  output logic [LANES-1:0]       ready_o,
  input  logic [SRC_W-1:0]       sel_i,
  output logic [LANES-1:0]       in_zero_o,
  output logic [LANES*WIDTH-1:0] operand_o,
  output logic [LANES-1:0]       op_valid_o,
  input  logic [LANES-1:0]       op_ready_i,
  output logic [LANES*SRC_W-1:0] op_src_o,
  output logic [LANES-1:0]       op_zero_o,
  output logic [SRC_W-1:0]       rot_o
);

  logic                   stage_free;
  logic                   fire;
  logic [SRC_W-1:0]       rot_q;
  logic [SRC_W-1:0]       rot_use;
  logic [SRC_W-1:0]       rot_next;
  logic [WIDTH-1:0]       lane_data [LANES];
  logic [LANES*WIDTH-1:0] routed_data;
  logic [LANES*SRC_W-1:0] routed_src;
  logic [LANES-1:0]       routed_zero;
  logic [LANES-1:0]       op_valid_q;
  logic [LANES*WIDTH-1:0] operand_q;
  logic [LANES*SRC_W-1:0] src_q;
  logic [LANES-1:0]       zero_q;

  // A batch fires only when every output lane can take a new operand and every pointer has one
  always_comb begin
    stage_free = &(~op_valid_q | op_ready_i);
    fire       = stage_free & (&valid_i) & ~flush_i;
    ready_o    = {LANES{fire}};
  end

  // Split the flat input bus into per-pointer operands and flag the zero ones
  always_comb begin
    in_zero_o = '0;
    for (int p = 0; p < LANES; p++) begin
      lane_data[p] = data_i[p*WIDTH +: WIDTH];
      in_zero_o[p] = (data_i[p*WIDTH +: WIDTH] == '0);
    end
  end

  // Rotation source: internal round-robin counter, or the requested amount folded into range
  generate
    if (MODE == 1) begin : g_round_robin
      always_comb begin
        rot_use = rot_q;
        if (rot_q == SRC_W'(LANES - 1)) begin
          rot_next = '0;
        end else begin
          rot_next = rot_q + 1'b1;
        end
      end
    end else begin : g_external_sel
      always_comb begin
        rot_use  = SRC_W'(int'(sel_i) % LANES);
        rot_next = rot_use;
      end
    end
  endgenerate

  // Rotation crossbar: output lane k is fed from pointer (k + rotation) mod LANES
  always_comb begin
    routed_data = '0;
    routed_src  = '0;
    routed_zero = '0;
    for (int k = 0; k < LANES; k++) begin
      int               s;
      logic [SRC_W-1:0] sidx;
      s = k + int'(rot_use);
      if (s >= LANES) begin
        s = s - LANES;
      end
      sidx                           = SRC_W'(s);
      routed_src[k*SRC_W +: SRC_W]   = sidx;
      routed_data[k*WIDTH +: WIDTH]  = lane_data[sidx];
      routed_zero[k]                 = in_zero_o[sidx];
    end
  end

  // Output stage: flush wins over a fire, a fire reloads every lane, otherwise lanes drain on their own
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      op_valid_q <= '0;
      operand_q  <= '0;
      src_q      <= '0;
      zero_q     <= '0;
      rot_q      <= '0;
    end else if (flush_i) begin
      op_valid_q <= '0;
      rot_q      <= '0;
    end else if (fire) begin
      op_valid_q <= '1;
      operand_q  <= routed_data;
      src_q      <= routed_src;
      zero_q     <= routed_zero;
      rot_q      <= rot_next;
    end else begin
      op_valid_q <= op_valid_q & ~op_ready_i;
    end
  end

  assign operand_o  = operand_q;
  assign op_valid_o = op_valid_q;
  assign op_src_o   = src_q;
  assign op_zero_o  = zero_q;
  assign rot_o      = rot_q;

endmodule

// File: tb/tb_operand_dispatcher_n.sv
// tb_operand_dispatcher_n
// Three dispatcher instances (2 lanes/sel, 4 lanes/round-robin, 3 lanes/sel) share clock and
// reset. A driver issues randomized and directed batches and pushes the expected lane contents
// into per-lane queues; an independent monitor pops and compares whenever a lane is valid.

module tb_operand_dispatcher_n;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  s;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic preset_n;

  logic [63:0] data_v  [3];
  logic [3:0]  valid_v [3];
  logic [3:0]  rdy_v   [3];
  logic [1:0]  sel_v   [3];
  logic        flush_v [3];

  logic [1:0]  a_ready, a_inz, a_vld, a_zero, a_src;
  logic [31:0] a_opnd;
  logic        a_rot;
  logic [3:0]  b_ready, b_inz, b_vld, b_zero;
  logic [7:0]  b_src;
  logic [63:0] b_opnd;
  logic [1:0]  b_rot;
  logic [2:0]  c_ready, c_inz, c_vld, c_zero;
  logic [5:0]  c_src;
  logic [47:0] c_opnd;
  logic [1:0]  c_rot;

  logic [3:0]  held   [3];
  int          rot_m  [3];
  int          rot_d  [3];
  bit          fire_d [3];
  exp_t        q      [3][4][$];

  int n_cmp = 0;
  int n_err = 0;

  // Free-running clock
  always #5 clk = ~clk;

  operand_dispatcher_n #(.WIDTH(16), .LANES(2), .MODE(0)) dut_a (
    .clk(clk), .preset_n(preset_n), .flush_i(flush_v[0]), .data_i(data_v[0][31:0]),
    .valid_i(valid_v[0][1:0]), .ready_o(a_ready), .sel_i(sel_v[0][0:0]), .in_zero_o(a_inz),
    .operand_o(a_opnd), .op_valid_o(a_vld), .op_ready_i(rdy_v[0][1:0]), .op_src_o(a_src),
    .op_zero_o(a_zero), .rot_o(a_rot));

  operand_dispatcher_n #(.WIDTH(16), .LANES(4), .MODE(1)) dut_b (
    .clk(clk), .preset_n(preset_n), .flush_i(flush_v[1]), .data_i(data_v[1]),
    .valid_i(valid_v[1]), .ready_o(b_ready), .sel_i(sel_v[1]), .in_zero_o(b_inz),
    .operand_o(b_opnd), .op_valid_o(b_vld), .op_ready_i(rdy_v[1]), .op_src_o(b_src),
    .op_zero_o(b_zero), .rot_o(b_rot));

  operand_dispatcher_n #(.WIDTH(16), .LANES(3), .MODE(0)) dut_c (
    .clk(clk), .preset_n(preset_n), .flush_i(flush_v[2]), .data_i(data_v[2][47:0]),
    .valid_i(valid_v[2][2:0]), .ready_o(c_ready), .sel_i(sel_v[2]), .in_zero_o(c_inz),
    .operand_o(c_opnd), .op_valid_o(c_vld), .op_ready_i(rdy_v[2][2:0]), .op_src_o(c_src),
    .op_zero_o(c_zero), .rot_o(c_rot));

  function automatic int lanes(input int u);
    return (u == 0) ? 2 : ((u == 1) ? 4 : 3);
  endfunction

  function automatic logic [3:0] mask(input int u);
    return 4'((1 << lanes(u)) - 1);
  endfunction

  function automatic logic [3:0] get_valid(input int u);
    case (u)
      0:       return {2'b00, a_vld};
      1:       return b_vld;
      default: return {1'b0, c_vld};
    endcase
  endfunction

  function automatic logic [3:0] get_ready(input int u);
    case (u)
      0:       return {2'b00, a_ready};
      1:       return b_ready;
      default: return {1'b0, c_ready};
    endcase
  endfunction

  function automatic logic [3:0] get_inzero(input int u);
    case (u)
      0:       return {2'b00, a_inz};
      1:       return b_inz;
      default: return {1'b0, c_inz};
    endcase
  endfunction

  function automatic logic [3:0] get_zero(input int u);
    case (u)
      0:       return {2'b00, a_zero};
      1:       return b_zero;
      default: return {1'b0, c_zero};
    endcase
  endfunction

  function automatic logic [1:0] get_rot(input int u);
    case (u)
      0:       return {1'b0, a_rot};
      1:       return b_rot;
      default: return c_rot;
    endcase
  endfunction

  function automatic logic [15:0] get_opnd(input int u, input int k);
    case (u)
      0:       return a_opnd[k*16 +: 16];
      1:       return b_opnd[k*16 +: 16];
      default: return c_opnd[k*16 +: 16];
    endcase
  endfunction

  function automatic logic [1:0] get_src(input int u, input int k);
    case (u)
      0:       return {1'b0, a_src[k]};
      1:       return b_src[k*2 +: 2];
      default: return c_src[k*2 +: 2];
    endcase
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] d;
    for (int k = 0; k < 4; k++) begin
      d[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    end
    return d;
  endfunction

  // One comparison: counts it, reports a FAIL line on difference
  task automatic checkOutput(input string name, input int u, input logic [31:0] act,
                             input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s unit%0d actual=%0h required=%0h at %0t", name, u, act, req, $time);
    end
  endtask

  // Reference model of one clock edge, using the inputs that were applied before it
  task automatic modelEdge(input int u);
    if (flush_v[u]) begin
      held[u]  = 4'h0;
      rot_m[u] = 0;
    end else if (fire_d[u]) begin
      held[u]  = mask(u);
      rot_m[u] = (u == 1) ? (rot_m[u] + 1) % lanes(u) : rot_d[u];
    end else begin
      held[u] = held[u] & ~rdy_v[u];
    end
  endtask

  // Drive one unit's inputs; if the batch should fire, queue what each lane must show next
  task automatic applyStimulus(input int u, input logic [63:0] d, input logic [3:0] v,
                               input logic [3:0] r, input logic f, input logic [1:0] s);
    int   l;
    int   rot;
    bit   fire;
    exp_t e;
    l          = lanes(u);
    data_v[u]  = d;
    valid_v[u] = v & mask(u);
    rdy_v[u]   = r & mask(u);
    flush_v[u] = f;
    sel_v[u]   = s;
    if (u == 1) rot = rot_m[u];
    else        rot = ((u == 0) ? int'(s[0]) : int'(s)) % l;
    fire = (((~held[u] | rdy_v[u]) & mask(u)) == mask(u)) && (valid_v[u] == mask(u)) && !f;
    fire_d[u] = fire;
    rot_d[u]  = rot;
    if (fire) begin
      for (int k = 0; k < l; k++) begin
        int sidx;
        sidx = (k + rot) % l;
        e.d  = d[sidx*16 +: 16];
        e.s  = 2'(sidx);
        e.z  = (e.d == 16'h0000);
        q[u][k].push_back(e);
      end
    end
  endtask

  task automatic idle(input int u);
    applyStimulus(u, 64'h0, 4'h0, 4'hf, 1'b0, 2'b00);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) modelEdge(u);
  endtask

  task automatic resetChecks();
    for (int u = 0; u < 3; u++) begin
      checkOutput("rst_op_valid", u, 32'(get_valid(u)), 32'h0);
      checkOutput("rst_op_zero", u, 32'(get_zero(u)), 32'h0);
      checkOutput("rst_rot", u, 32'(get_rot(u)), 32'h0);
      for (int k = 0; k < lanes(u); k++) begin
        checkOutput("rst_operand", u, 32'(get_opnd(u, k)), 32'h0);
        checkOutput("rst_src", u, 32'(get_src(u, k)), 32'h0);
      end
    end
  endtask

  // Asynchronous reset in the middle of a held batch
  task automatic midReset();
    advance();
    for (int u = 0; u < 3; u++) idle(u);
    advance();
    for (int u = 0; u < 3; u++) applyStimulus(u, rand_data(), 4'hf, 4'h0, 1'b0, 2'($urandom));
    @(posedge clk);
    #2;
    for (int u = 0; u < 3; u++) begin
      modelEdge(u);
      checkOutput("pre_rst_full", u, 32'(get_valid(u)), 32'(mask(u)));
    end
    preset_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      idle(u);
      held[u]   = 4'h0;
      rot_m[u]  = 0;
      fire_d[u] = 1'b0;
      for (int k = 0; k < 4; k++) q[u][k].delete();
    end
    #1;
    resetChecks();
    @(posedge clk);
    #2;
    preset_n = 1'b1;
  endtask

  // Monitor: compare every valid lane against the head of its queue, pop on handshake
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      logic [3:0] ez;
      ez = 4'h0;
      for (int k = 0; k < lanes(u); k++) ez[k] = (data_v[u][k*16 +: 16] == 16'h0000);
      checkOutput("op_valid", u, 32'(get_valid(u)), 32'(held[u]));
      checkOutput("rot", u, 32'(get_rot(u)), 32'(rot_m[u]));
      checkOutput("ready_o", u, 32'(get_ready(u)), fire_d[u] ? 32'(mask(u)) : 32'h0);
      checkOutput("in_zero", u, 32'(get_inzero(u)), 32'(ez));
      for (int k = 0; k < lanes(u); k++) begin
        if (held[u][k]) begin
          if (q[u][k].size() == 0) begin
            checkOutput("scoreboard_empty", u, 32'h0, 32'h1);
          end else begin
            checkOutput("operand", u, 32'(get_opnd(u, k)), 32'(q[u][k][0].d));
            checkOutput("src", u, 32'(get_src(u, k)), 32'(q[u][k][0].s));
            checkOutput("op_zero", u, 32'(get_zero(u)) >> k & 32'h1, 32'(q[u][k][0].z));
            if (rdy_v[u][k] && !flush_v[u]) void'(q[u][k].pop_front());
          end
        end
      end
      if (flush_v[u]) begin
        for (int k = 0; k < 4; k++) q[u][k].delete();
      end
    end
  end

  initial begin
    preset_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      held[u]   = 4'h0;
      rot_m[u]  = 0;
      rot_d[u]  = 0;
      fire_d[u] = 1'b0;
      idle(u);
    end
    repeat (2) @(posedge clk);
    #2;
    resetChecks();
    preset_n = 1'b1;

    // Legacy 2-way swap with registered path tag
    advance();
    applyStimulus(0, {32'h0, 16'h0005, 16'h0000}, 4'h3, 4'h3, 1'b0, 2'b01);
    idle(1);
    idle(2);
    #1;
    checkOutput("t2_in_zero", 0, 32'(get_inzero(0)), 32'h1);
    checkOutput("t2_ready", 0, 32'(get_ready(0)), 32'h3);
    advance();
    checkOutput("t2_operand0", 0, 32'(get_opnd(0, 0)), 32'h5);
    checkOutput("t2_src0", 0, 32'(get_src(0, 0)), 32'h1);
    checkOutput("t2_operand1", 0, 32'(get_opnd(0, 1)), 32'h0);
    checkOutput("t2_src1", 0, 32'(get_src(0, 1)), 32'h0);
    checkOutput("t2_op_zero", 0, 32'(get_zero(0)), 32'h2);

    // Backpressure on lane 1 stalls the next batch until it drains
    applyStimulus(0, rand_data(), 4'h3, 4'h1, 1'b0, 2'b00);
    advance();
    applyStimulus(0, rand_data(), 4'h3, 4'h1, 1'b0, 2'b01);
    #1;
    checkOutput("t3_stall", 0, 32'(get_ready(0)), 32'h0);
    advance();
    applyStimulus(0, rand_data(), 4'h3, 4'h3, 1'b0, 2'b00);
    #1;
    checkOutput("t3_refire", 0, 32'(get_ready(0)), 32'h3);
    advance();
    idle(0);

    // Partial valid never dispatches
    applyStimulus(1, rand_data(), 4'b1011, 4'hf, 1'b0, 2'b00);
    #1;
    checkOutput("t5_partial", 1, 32'(get_ready(1)), 32'h0);
    advance();
    applyStimulus(1, rand_data(), 4'b1111, 4'hf, 1'b0, 2'b00);
    #1;
    checkOutput("t5_full", 1, 32'(get_ready(1)), 32'hf);

    // Flush beats a fire that would otherwise happen
    applyStimulus(2, rand_data(), 4'h7, 4'h0, 1'b0, 2'b10);
    advance();
    idle(1);
    applyStimulus(2, rand_data(), 4'h7, 4'h7, 1'b1, 2'b01);
    #1;
    checkOutput("t6_ready", 2, 32'(get_ready(2)), 32'h0);
    advance();
    checkOutput("t6_valid", 2, 32'(get_valid(2)), 32'h0);
    checkOutput("t6_rot", 2, 32'(get_rot(2)), 32'h0);
    idle(2);

    // Randomized traffic with a reset and a round-robin burst in the middle
    for (int i = 0; i < 700; i++) begin
      if (i == 350) begin
        midReset();
        advance();
        applyStimulus(1, rand_data(), 4'hf, 4'hf, 1'b0, 2'b00);
        idle(0);
        idle(2);
        for (int j = 0; j < 5; j++) begin
          advance();
          checkOutput("t4_src_lane0", 1, 32'(get_src(1, 0)), 32'(j % 4));
          checkOutput("t4_rot", 1, 32'(get_rot(1)), 32'((j + 1) % 4));
          if (j < 4) applyStimulus(1, rand_data(), 4'hf, 4'hf, 1'b0, 2'b00);
          else       idle(1);
        end
      end
      advance();
      for (int u = 0; u < 3; u++) begin
        logic [3:0] v;
        logic [3:0] r;
        v = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hf;
        r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hf;
        applyStimulus(u, rand_data(), v, r, ($urandom_range(0, 24) == 0), 2'($urandom));
      end
    end

    // Drain and make sure nothing was lost
    repeat (3) begin
      advance();
      for (int u = 0; u < 3; u++) idle(u);
    end
    @(negedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      int left;
      left = 0;
      for (int k = 0; k < 4; k++) left += q[u][k].size();
      checkOutput("leftover", u, 32'(left), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
